// File: rtl/reg_file_2ph.sv
// Two-phase register file: FETCH/EXEC phase machine, instruction latch, 2R1W array.
// Optional same-cycle write-to-read forwarding enabled by REG_FILE_BYPASS_EN.
module reg_file_2ph #(
    parameter int W  = 8,
    parameter int D  = 4,
    parameter int IW = 9
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          hold,
    input  logic          write_en,
    input  logic [D-1:0]  raddrA,
    input  logic [D-1:0]  raddrB,
    input  logic [D-1:0]  waddr,
    input  logic [W-1:0]  data_in,
    input  logic [IW-1:0] inst_in,
    output logic [W-1:0]  data_outA,
    output logic [W-1:0]  data_outB,
    output logic [IW-1:0] read_inst,
    output logic          inst_valid,
    output logic          phase
);

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } phase_t;

    phase_t       state;
    logic [W-1:0] regs [2**D];
    logic         wr;

    assign phase = state;
    assign wr    = (state == EXEC) && write_en && !hold && (waddr != '0);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state      <= FETCH;
            read_inst  <= '0;
            inst_valid <= 1'b0;
            for (int i = 0; i < 2**D; i++) regs[i] <= '0;
        end else if (!hold) begin
            unique case (state)
                FETCH: begin
                    read_inst  <= inst_in;
                    inst_valid <= 1'b1;
                    state      <= EXEC;
                end
                EXEC: begin
                    if (wr) regs[waddr] <= data_in;
                    state <= FETCH;
                end
            endcase
        end
    end

    function automatic logic [W-1:0] rd(input logic [D-1:0] a);
        logic [W-1:0] v;
        v = '0;
        if (state == EXEC && a != '0) begin
`ifdef REG_FILE_BYPASS_EN
            if (wr && a == waddr) v = data_in;
            else v = regs[a];
`else
            v = regs[a];
`endif
        end
        return v;
    endfunction

    assign data_outA = rd(raddrA);
    assign data_outB = rd(raddrB);

endmodule

// File: tb/tb_reg_file_2ph.sv
// Self-checking bench for reg_file_2ph: directed scenarios then random traffic
// against an array-based behavioural model.
module tb_reg_file_2ph;

    logic       CLK = 1'b0;
    logic       reset, hold, write_en;
    logic [3:0] raddrA, raddrB, waddr;
    logic [7:0] data_in;
    logic [8:0] inst_in;
    logic [7:0] data_outA, data_outB;
    logic [8:0] read_inst;
    logic       inst_valid, phase;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [16];
    logic       m_exec;
    logic [8:0] m_inst;
    logic       m_valid;
    logic [7:0] seen_a, seen_b;

    always #5 CLK = ~CLK;

    reg_file_2ph dut (
        .CLK(CLK), .reset(reset), .hold(hold), .write_en(write_en),
        .raddrA(raddrA), .raddrB(raddrB), .waddr(waddr),
        .data_in(data_in), .inst_in(inst_in),
        .data_outA(data_outA), .data_outB(data_outB),
        .read_inst(read_inst), .inst_valid(inst_valid), .phase(phase)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_rd(input logic [3:0] a, input logic h,
                                            input logic we, input logic [3:0] wa,
                                            input logic [7:0] d);
        if (!m_exec || a == 0) return 8'h00;
`ifdef REG_FILE_BYPASS_EN
        if (we && !h && wa != 0 && wa == a) return d;
`endif
        return mem[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        m_exec  = 1'b0;
        m_inst  = 9'h000;
        m_valid = 1'b0;
    endtask

    task automatic step(input logic rst, input logic h, input logic we,
                        input logic [3:0] ra, input logic [3:0] rb,
                        input logic [3:0] wa, input logic [7:0] d,
                        input logic [8:0] ins);
        @(negedge CLK);
        reset = rst; hold = h; write_en = we;
        raddrA = ra; raddrB = rb; waddr = wa;
        data_in = d; inst_in = ins;
        #1;
        seen_a = data_outA;
        seen_b = data_outB;
        check("outA", {24'h0, data_outA}, {24'h0, model_rd(ra, h, we, wa, d)});
        check("outB", {24'h0, data_outB}, {24'h0, model_rd(rb, h, we, wa, d)});
        @(posedge CLK);
        if (rst) model_reset();
        else if (!h) begin
            if (!m_exec) begin
                m_inst  = ins;
                m_valid = 1'b1;
            end else if (we && wa != 0) begin
                mem[wa] = d;
            end
            m_exec = !m_exec;
        end
        #1;
        check("phase", {31'h0, phase}, {31'h0, m_exec});
        check("inst", {23'h0, read_inst}, {23'h0, m_inst});
        check("valid", {31'h0, inst_valid}, {31'h0, m_valid});
    endtask

    initial begin
        reset = 1'b1; hold = 1'b1; write_en = 1'b1;
        raddrA = 4'd1; raddrB = 4'd2; waddr = 4'd1;
        data_in = 8'hEE; inst_in = 9'h1FF;
        @(posedge CLK);
        @(posedge CLK);
        model_reset();
        step(1, 1, 1, 1, 2, 1, 8'hEE, 9'h1FF);
        check("rst_phase", {31'h0, phase}, 32'h0);
        check("rst_valid", {31'h0, inst_valid}, 32'h0);
        check("rst_inst", {23'h0, read_inst}, 32'h0);

        step(0, 0, 0, 1, 2, 0, 8'h00, 9'h1A5);
        check("inst_1a5", {23'h0, read_inst}, 32'h1A5);
        check("exec_ph", {31'h0, phase}, 32'h1);
        step(0, 0, 1, 3, 0, 3, 8'h5C, 9'h000);
        check("back_fetch", {31'h0, phase}, 32'h0);
        step(0, 0, 0, 3, 0, 0, 8'h00, 9'h0AA);
        check("fetch_a0", {24'h0, seen_a}, 32'h0);
        check("fetch_b0", {24'h0, seen_b}, 32'h0);
        step(0, 0, 1, 3, 0, 0, 8'hFF, 9'h000);
        check("rd_5c", {24'h0, seen_a}, 32'h5C);
        check("rd_z", {24'h0, seen_b}, 32'h0);
        step(0, 0, 1, 7, 0, 7, 8'hAA, 9'h000);
        step(0, 1, 1, 7, 0, 7, 8'hBB, 9'h000);
        check("hold_ph", {31'h0, phase}, 32'h1);
        step(0, 0, 1, 0, 7, 5, 8'h11, 9'h000);
        check("r0", {24'h0, seen_a}, 32'h0);
        check("r7", {24'h0, seen_b}, 32'h0);
        step(0, 0, 0, 0, 0, 0, 8'h00, 9'h000);
        step(0, 0, 1, 5, 5, 5, 8'h33, 9'h000);
`ifdef REG_FILE_BYPASS_EN
        check("byp", {24'h0, seen_a}, 32'h33);
`else
        check("nobyp", {24'h0, seen_a}, 32'h11);
`endif
        step(0, 0, 0, 0, 0, 0, 8'h00, 9'h000);
        step(0, 0, 0, 5, 3, 0, 8'h00, 9'h000);
        check("r5_new", {24'h0, seen_a}, 32'h33);
        step(0, 0, 0, 0, 0, 0, 8'h00, 9'h000);
        step(1, 0, 1, 2, 0, 2, 8'h77, 9'h000);
        check("rst_exec", {31'h0, phase}, 32'h0);
        step(0, 0, 0, 2, 5, 0, 8'h00, 9'h000);
        step(0, 0, 0, 2, 5, 0, 8'h00, 9'h000);
        check("r2_clr", {24'h0, seen_a}, 32'h0);
        check("r5_clr", {24'h0, seen_b}, 32'h0);

        for (int n = 0; n < 1500; n++) begin
            logic [3:0] ra, wa;
            ra = 4'($urandom_range(0, 15));
            wa = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 4) == 0),
                 1'($urandom), ra, 4'($urandom_range(0, 15)), wa,
                 8'($urandom), 9'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
